// File: rtl/cam_stream_tx.sv
// cam_stream_tx: synthetic camera pixel stream (pclk/vsync/href/8-bit bus).
// Emits YUYV-style bytes: Y on even byte slots, fixed chroma 8'h80 on odd.
// Optional build macro CAM_TX_NOISE_EN: XORs LFSR noise into Y bits [1:0].
module cam_stream_tx #(
  parameter int         H_ACTIVE   = 640,
  parameter int         V_ACTIVE   = 480,
  parameter int         H_BLANK    = 144,
  parameter int         V_SYNC     = 3,
  parameter int         V_BACK     = 17,
  parameter int         V_FRONT    = 10,
  parameter logic [7:0] GRAY_LEVEL = 8'h40,
  parameter int         SPOT_SIZE  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] pattern_sel,
  input  logic [9:0] spot_x,
  input  logic [8:0] spot_y,
  output logic       pclk_out,
  output logic       vsync,
  output logic       href,
  output logic [7:0] data,
  output logic       frame_done
);

  localparam int LINE_LEN = 2*H_ACTIVE + H_BLANK;
  localparam int BW       = (LINE_LEN > 2) ? $clog2(LINE_LEN) : 1;
  localparam int VMAX01   = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
  localparam int VMAX23   = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int VMAX     = (VMAX01 > VMAX23) ? VMAX01 : VMAX23;
  localparam int LW       = (VMAX > 2) ? $clog2(VMAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT
  } state_t;

  state_t        state, state_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [LW-1:0] lcnt, lcnt_n;
  logic [LW-1:0] last_line;
  logic          line_end;
  logic          start;     // frame begins on this tick: latch the config
  logic          done;      // last tick of VFRONT

  // per-frame configuration, frozen at frame start
  logic [1:0]    cfg_pat;
  logic [9:0]    cfg_sx;
  logic [8:0]    cfg_sy;

  // next-position pixel view
  logic [10:0]   x_n, y_n;
  logic [10:0]   sx11, sy11, ex11, ey11;
  logic          in_x, in_y;
  logic [7:0]    y_nom, y_out;
  logic          vsync_n, href_n;
  logic [7:0]    data_n;

  // Output updates happen on the pclk falling edge, i.e. when pclk_out is 1.
  logic tick;
  assign tick = pclk_out;

  // Last line index of the current vertical region.
  always_comb begin
    case (state)
      S_VSYNC:  last_line = LW'(V_SYNC - 1);
      S_VBACK:  last_line = LW'(V_BACK - 1);
      S_ACTIVE: last_line = LW'(V_ACTIVE - 1);
      default:  last_line = LW'(V_FRONT - 1);
    endcase
  end

  // Next-state and counter advance; evaluated every clk, committed on tick.
  always_comb begin
    state_n  = state;
    bcnt_n   = bcnt;
    lcnt_n   = lcnt;
    start    = 1'b0;
    done     = 1'b0;
    line_end = (bcnt == BW'(LINE_LEN - 1));
    case (state)
      S_IDLE: begin
        bcnt_n = '0;
        lcnt_n = '0;
        if (enable) begin
          state_n = S_VSYNC;
          start   = 1'b1;
        end
      end
      default: begin
        if (line_end) begin
          bcnt_n = '0;
          if (lcnt == last_line) begin
            lcnt_n = '0;
            case (state)
              S_VSYNC:  state_n = S_VBACK;
              S_VBACK:  state_n = S_ACTIVE;
              S_ACTIVE: state_n = S_VFRONT;
              default: begin
                // back-to-back frames: frame_done and VSYNC share this tick
                done    = 1'b1;
                start   = enable;
                state_n = enable ? S_VSYNC : S_IDLE;
              end
            endcase
          end else begin
            lcnt_n = lcnt + LW'(1);
          end
        end else begin
          bcnt_n = bcnt + BW'(1);
        end
      end
    endcase
  end

  // Pixel coordinates of the byte about to be driven, 11-bit for clipping.
  assign x_n  = 11'(bcnt_n >> 1);
  assign y_n  = 11'(lcnt_n);
  assign sx11 = {1'b0, cfg_sx};
  assign sy11 = {2'b00, cfg_sy};
  assign ex11 = sx11 + 11'(SPOT_SIZE);
  assign ey11 = sy11 + 11'(SPOT_SIZE);
  assign in_x = (x_n >= sx11) && (x_n < ex11);
  assign in_y = (y_n >= sy11) && (y_n < ey11);

  // Luma pattern generator.
  always_comb begin
    y_nom = GRAY_LEVEL;
    case (cfg_pat)
      2'd1:    y_nom = x_n[9:2];
      2'd2:    y_nom = (x_n[5] ^ y_n[5]) ? 8'hF0 : 8'h10;
      2'd3:    y_nom = (in_x && in_y) ? 8'hFF : 8'h20;
      default: y_nom = GRAY_LEVEL;
    endcase
  end

`ifdef CAM_TX_NOISE_EN
  logic [15:0] lfsr;
  logic        lfsr_step;
  assign lfsr_step = tick && (state_n == S_ACTIVE) && !bcnt_n[0];
  assign y_out     = y_nom ^ {6'b0, lfsr[1:0]};

  // Fibonacci LFSR x^16+x^14+x^13+x^11, one step per Y slot in ACTIVE.
  always_ff @(posedge clk) begin
    if (reset)          lfsr <= 16'hACE1;
    else if (lfsr_step) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
`else
  assign y_out = y_nom;
`endif

  // Bus values for the next position.
  always_comb begin
    vsync_n = (state_n == S_VSYNC);
    href_n  = (state_n == S_ACTIVE) && (32'(bcnt_n) < 2*H_ACTIVE);
    data_n  = 8'h00;
    if (href_n) data_n = bcnt_n[0] ? 8'h80 : y_out;
  end

  // State, counters and frame config register; advance only on tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      bcnt    <= '0;
      lcnt    <= '0;
      cfg_pat <= 2'd0;
      cfg_sx  <= 10'd0;
      cfg_sy  <= 9'd0;
    end else if (tick) begin
      state <= state_n;
      bcnt  <= bcnt_n;
      lcnt  <= lcnt_n;
      if (start) begin
        cfg_pat <= pattern_sel;
        cfg_sx  <= spot_x;
        cfg_sy  <= spot_y;
      end
    end
  end

  // Pixel clock and registered outputs; frame_done is a single-clk pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      pclk_out   <= 1'b0;
      vsync      <= 1'b0;
      href       <= 1'b0;
      data       <= 8'h00;
      frame_done <= 1'b0;
    end else begin
      pclk_out   <= ~pclk_out;
      frame_done <= 1'b0;
      if (tick) begin
        vsync      <= vsync_n;
        href       <= href_n;
        data       <= data_n;
        frame_done <= done;
      end
    end
  end

endmodule

// File: tb/tb_cam_stream_tx.sv
// Scoreboard bench for cam_stream_tx: small-frame instance (a) and a wide
// line instance (b) for the horizontal ramp.
module tb_cam_stream_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_a, enable_a, pclk_a, vs_a, hr_a, fd_a;
  logic [1:0] pat_a;
  logic [9:0] sx_a;
  logic [8:0] sy_a;
  logic [7:0] d_a;

  logic       reset_b, enable_b, pclk_b, vs_b, hr_b, fd_b;
  logic [1:0] pat_b;
  logic [9:0] sx_b;
  logic [8:0] sy_b;
  logic [7:0] d_b;

  cam_stream_tx #(.H_ACTIVE(8), .V_ACTIVE(4), .H_BLANK(4), .V_SYNC(1),
                  .V_BACK(1), .V_FRONT(1), .GRAY_LEVEL(8'h40), .SPOT_SIZE(4)) dut_a (
    .clk(clk), .reset(reset_a), .enable(enable_a), .pattern_sel(pat_a),
    .spot_x(sx_a), .spot_y(sy_a), .pclk_out(pclk_a), .vsync(vs_a),
    .href(hr_a), .data(d_a), .frame_done(fd_a));

  cam_stream_tx #(.H_ACTIVE(1024), .V_ACTIVE(1), .H_BLANK(4), .V_SYNC(1),
                  .V_BACK(1), .V_FRONT(1)) dut_b (
    .clk(clk), .reset(reset_b), .enable(enable_b), .pattern_sel(pat_b),
    .spot_x(sx_b), .spot_y(sy_b), .pclk_out(pclk_b), .vsync(vs_b),
    .href(hr_b), .data(d_b), .frame_done(fd_b));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Hand-derived Y for the 8x4 instance.
  function automatic logic [7:0] exp_y(input int pat, input int x, input int y);
    case (pat)
      0:       return 8'h40;
      2:       return 8'h10;                                   // x,y < 32: x[5]^y[5]=0
      3:       return (y >= 2 && x >= 6) ? 8'hFF : 8'h20;      // spot (6,2) size 4, clipped
      default: return 8'h00;
    endcase
  endfunction

  task automatic push_frame_a(input int pat);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++) begin
        qa.push_back(exp_y(pat, x, y));
        qa.push_back(8'h80);
      end
  endtask

  task automatic wait_fd_a(input string nm);
    int k = 0;
    do begin @(negedge clk); k++; end while (fd_a !== 1'b1 && k < 400);
    chk(nm, fd_a, 1'b1);
  endtask

  // Monitor a: sample where the receiver would (pclk high), pop and compare.
  initial begin
    int hrun = 0;
    int vrun = 0;
    logic fd_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_a) begin
        hrun = 0; vrun = 0; fd_prev = 1'b0;
      end else begin
        if (fd_a) chk("a_frame_done_width", fd_prev, 1'b0);
        fd_prev = fd_a;
        if (pclk_a) begin
          if (hr_a) begin
            hrun++;
            if (qa.size() == 0) begin
              n_cmp++; n_bad++;
              $display("FAIL a_extra_byte: got %0h expected none (cycle %0d)", d_a, cyc);
            end else chk("a_byte", d_a, qa.pop_front());
          end else begin
            if (hrun > 0) chk("a_href_run", hrun, 16);
            hrun = 0;
            chk("a_blank_data", d_a, 8'h00);
          end
          if (vs_a) vrun++;
          else begin
            if (vrun > 0) chk("a_vsync_ticks", vrun, 20);
            vrun = 0;
          end
        end
      end
    end
  end

  // Monitor b: ramp bytes, plus an explicit look at x=1023.
  initial begin
    int nb = 0;
    forever begin
      @(negedge clk);
      if (!reset_b && pclk_b && hr_b) begin
        nb++;
        if (qb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL b_extra_byte: got %0h expected none (cycle %0d)", d_b, cyc);
        end else chk("b_byte", d_b, qb.pop_front());
        if (nb == 2047) chk("b_x1023_y", d_b, 8'hFF);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, k, toggles, noisy;
    logic p_prev;
    reset_a = 1; enable_a = 0; pat_a = 0; sx_a = 0; sy_a = 0;
    reset_b = 1; enable_b = 0; pat_b = 2'd1; sx_b = 0; sy_b = 0;
    repeat (4) @(negedge clk);
    chk("rst_pclk", pclk_a, 1'b0);
    chk("rst_vsync", vs_a, 1'b0);
    chk("rst_href", hr_a, 1'b0);
    chk("rst_data", d_a, 8'h00);
    chk("rst_frame_done", fd_a, 1'b0);
    reset_a = 0;
    @(negedge clk); chk("pclk_rise", pclk_a, 1'b1);
    @(negedge clk); chk("pclk_fall", pclk_a, 1'b0);

    // solid gray, two frames; pattern switched to checkerboard mid frame 2
    push_frame_a(0);
    push_frame_a(0);
    enable_a = 1;
    wait_fd_a("a_fd1");
    t0 = cyc;
    repeat (50) @(negedge clk);
    pat_a = 2'd2;
    wait_fd_a("a_fd2");
    chk("a_fd_period2", cyc - t0, 280);
    t0 = cyc;
    push_frame_a(2);
    repeat (50) @(negedge clk);
    pat_a = 2'd3; sx_a = 10'd6; sy_a = 9'd2;
    wait_fd_a("a_fd3");
    chk("a_fd_period3", cyc - t0, 280);
    t0 = cyc;
    push_frame_a(3);

    // drop enable inside the second active line of frame 4
    repeat (130) @(negedge clk);
    chk("a_href_line2", hr_a, 1'b1);
    enable_a = 0;
    wait_fd_a("a_fd4");
    chk("a_fd_period4", cyc - t0, 280);
    toggles = 0; noisy = 0; p_prev = pclk_a;
    repeat (100) begin
      @(negedge clk);
      if (pclk_a !== p_prev) toggles++;
      p_prev = pclk_a;
      if (vs_a !== 1'b0 || hr_a !== 1'b0 || d_a !== 8'h00 || fd_a !== 1'b0) noisy++;
    end
    chk("a_idle_quiet", noisy, 0);
    chk("a_idle_pclk_toggles", toggles, 100);
    chk("a_queue_drained1", qa.size(), 0);

    // reset in the middle of an active line
    pat_a = 2'd0;
    push_frame_a(0);
    enable_a = 1;
    k = 0;
    do begin @(negedge clk); k++; end while (!(hr_a === 1'b1 && pclk_a === 1'b1) && k < 400);
    chk("a_href_before_reset", hr_a, 1'b1);
    @(negedge clk);
    reset_a = 1;
    @(negedge clk);
    chk("abort_href", hr_a, 1'b0);
    chk("abort_data", d_a, 8'h00);
    chk("abort_vsync", vs_a, 1'b0);
    chk("abort_pclk", pclk_a, 1'b0);
    qa.delete();
    repeat (3) @(negedge clk);
    push_frame_a(0);
    reset_a = 0;
    k = 0;
    do begin @(negedge clk); k++; end while (vs_a !== 1'b1 && k < 10);
    chk("a_fresh_vsync", vs_a, 1'b1);
    enable_a = 0;
    wait_fd_a("a_fd5");
    chk("a_queue_drained2", qa.size(), 0);

    // horizontal ramp over a 1024-pixel line
    for (int x = 0; x < 1024; x++) begin
      logic [9:0] xv;
      xv = 10'(x);
      qb.push_back(xv[9:2]);
      qb.push_back(8'h80);
    end
    reset_b = 0;
    enable_b = 1;
    k = 0;
    do begin @(negedge clk); k++; end while (vs_b !== 1'b1 && k < 10);
    chk("b_vsync", vs_b, 1'b1);
    enable_b = 0;
    k = 0;
    do begin @(negedge clk); k++; end while (fd_b !== 1'b1 && k < 20000);
    chk("b_frame_done", fd_b, 1'b1);
    chk("b_queue_drained", qb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
